cdc_handshake_tx: RTL and testbench
===================================

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, minimum 1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: depth of the ack synchroniser, minimum 2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1023: WAIT_ACK cycles before timeout is flagged, minimum 1; used only with CDC_HANDSHAKE_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port sreset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port axis_i_tvalid  input  1  source word valid.
REQ-007 SHALL have port axis_i_tready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port axis_i_tdata  input  WIDTH  source word.
REQ-009 SHALL have port xfer_data  output  WIDTH  registered word presented to the far domain.
REQ-010 SHALL have port xfer_req  output  1  two-phase request toggle to the far domain.
REQ-011 SHALL have port xfer_ack  input  1  two-phase ack toggle from the far domain; asynchronous to clk.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port timeout  output  1  sticky timeout flag; present only with CDC_HANDSHAKE_TIMEOUT_EN.

Function
REQ-014 SHALL pass xfer_ack through a SYNC_STAGES-deep synchroniser to produce ack_sync; no other logic uses xfer_ack.
REQ-015 SHALL implement FSM states STARTUP, IDLE and WAIT_ACK.
REQ-016 STARTUP SHALL last exactly SYNC_STAGES cycles after reset release, with axis_i_tready low, then go to IDLE; this flushes the unreset synchroniser.
REQ-017 In IDLE, axis_i_tready SHALL be 1; in every other state it SHALL be 0.
REQ-018 On axis_i_tvalid && axis_i_tready, the next edge SHALL load xfer_data with axis_i_tdata, invert xfer_req and enter WAIT_ACK, all in the same cycle.
REQ-019 xfer_data SHALL remain stable from that edge until the next accepted word.
REQ-020 In WAIT_ACK, when ack_sync == xfer_req, the next state SHALL be IDLE; otherwise the block stays in WAIT_ACK.
REQ-021 A word asserted with tvalid during STARTUP or WAIT_ACK SHALL be held by the source and SHALL NOT be lost or duplicated.
REQ-022 With xfer_ack looped back to xfer_req, accept-to-accept spacing SHALL be SYNC_STAGES+2 cycles.
REQ-023 An ack edge seen while in IDLE, meaning ack_sync != xfer_req, SHALL be ignored: no state change and no error.

Reset
REQ-024 While sreset is high: state STARTUP with startup counter 0, xfer_req=0, xfer_data=0, axis_i_tready=0, busy=1, timeout=0, timeout counter 0.
REQ-025 Reset asserted in WAIT_ACK SHALL abort the transfer with no completion; the far-domain receiver SHALL also be reset so that its ack returns to 0.

Configuration
REQ-026 With macro CDC_HANDSHAKE_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_ACK and increment each WAIT_ACK cycle, saturating at TIMEOUT_CYCLES.
REQ-027 With the macro defined, timeout SHALL go high on the cycle the counter reaches TIMEOUT_CYCLES and stay high until sreset; the FSM SHALL keep waiting and timeout SHALL NOT force IDLE.
REQ-028 Without the macro, the timeout port, counter and parameter use SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-029 Package cdc_handshake_pkg SHALL hold the state enum type and the default constants for SYNC_STAGES and TIMEOUT_CYCLES.
REQ-030 The ack synchroniser SHALL be one instance of the existing logic_cross_clock sub-module with STAGES=SYNC_STAGES; no other sub-modules.

Verification
REQ-031 Reset 3 cycles, then release, with tvalid=1 held -> tready=0 for exactly SYNC_STAGES=2 cycles, then 1; first word accepted on cycle 3 after release.
REQ-032 Loopback ack=req, send 0xA5, 0x3C, 0xFF back-to-back -> xfer_data takes each value in order; xfer_req toggles 0->1->0->1; accepts spaced 4 cycles apart.
REQ-033 Ack held at 0 after sending 0x11, with the macro and TIMEOUT_CYCLES=10 -> timeout rises on the 10th WAIT_ACK cycle and stays high; then toggle ack -> IDLE and timeout stays 1.
REQ-034 Spurious ack toggle while IDLE -> no state change, xfer_req unchanged; next word still accepted normally.
REQ-035 sreset pulsed in WAIT_ACK mid-transfer -> xfer_req=0 and xfer_data=0 next cycle, STARTUP re-entered, and no completion is counted.
REQ-036 Random tvalid gaps with ack delayed 0-20 cycles, 1000 words -> the scoreboard sees every word exactly once and in order.

Source files
------------

// File: rtl/cdc_handshake_pkg.sv
// Shared types and defaults for the two-phase CDC request/ack sender.
// Timeout support is built only with CDC_HANDSHAKE_TIMEOUT_EN defined.
package cdc_handshake_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP  = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1023;

endpackage

// File: rtl/logic_cross_clock.sv
// Multi-flop level synchroniser for a single asynchronous bit.
// Flops are intentionally unreset; the owner flushes them after reset.
module logic_cross_clock
  import cdc_handshake_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    r_sync <= {r_sync[STAGES-2:0], i_async};
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Two-phase request/ack sender: one AXI-stream word per toggle of xfer_req.
// Define CDC_HANDSHAKE_TIMEOUT_EN to add the sticky timeout output.
module cdc_handshake_tx
  import cdc_handshake_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             sreset,
  input  logic             axis_i_tvalid,
  output logic             axis_i_tready,
  input  logic [WIDTH-1:0] axis_i_tdata,
  output logic [WIDTH-1:0] xfer_data,
  output logic             xfer_req,
  input  logic             xfer_ack,
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic             busy
);

  localparam int SCW = $clog2(SYNC_STAGES);

  if (WIDTH < 1 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("cdc_handshake_tx: illegal parameter value");
  end

  state_e             r_state;
  state_e             w_state_nxt;
  logic [SCW-1:0]     r_scnt;
  logic [WIDTH-1:0]   r_data;
  logic               r_req;
  logic               w_ack_sync;
  logic               w_accept;
  logic               w_scnt_last;

  logic_cross_clock #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .i_async (xfer_ack),
    .o_sync  (w_ack_sync)
  );

  assign w_scnt_last = (r_scnt == SCW'(SYNC_STAGES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (1'b1)
      (r_state == ST_STARTUP): begin
        if (w_scnt_last) w_state_nxt = ST_IDLE;
      end
      (r_state == ST_IDLE): begin
        if (axis_i_tvalid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      (r_state == ST_WAIT_ACK): begin
        if (w_ack_sync == r_req) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state <= ST_STARTUP;
      r_scnt  <= '0;
      r_req   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= (r_state == ST_STARTUP) ? r_scnt + SCW'(1) : '0;
      if (w_accept) begin
        r_data <= axis_i_tdata;
        r_req  <= ~r_req;
      end
    end
  end

  assign axis_i_tready = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign xfer_data     = r_data;
  assign xfer_req      = r_req;

`ifdef CDC_HANDSHAKE_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0] r_tcnt;
  logic           r_timeout;

  // Flag only; the far side may still answer late, so keep waiting.
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_tcnt <= '0;
    end else if (r_state == ST_WAIT_ACK &&
                 r_tcnt != TCW'(TIMEOUT_CYCLES)) begin
      r_tcnt <= r_tcnt + TCW'(1);
      if (r_tcnt == TCW'(TIMEOUT_CYCLES - 1)) r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a loopback / delayed far side.
// Exercises timeout too when CDC_HANDSHAKE_TIMEOUT_EN is defined.
module tb_cdc_handshake_tx;

  localparam int W    = 8;
  localparam int SS   = 2;
  localparam int TOUT = 10;

  logic         clk = 1'b0;
  logic         sreset;
  logic         axis_i_tvalid;
  logic         axis_i_tready;
  logic [W-1:0] axis_i_tdata;
  logic [W-1:0] xfer_data;
  logic         xfer_req;
  logic         xfer_ack;
  logic         busy;
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
  logic         timeout;
`endif

  cdc_handshake_tx #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk           (clk),
    .sreset        (sreset),
    .axis_i_tvalid (axis_i_tvalid),
    .axis_i_tready (axis_i_tready),
    .axis_i_tdata  (axis_i_tdata),
    .xfer_data     (xfer_data),
    .xfer_req      (xfer_req),
    .xfer_ack      (xfer_ack),
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
    .timeout       (timeout),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          done  = 0;
  bit          pending = 0;
  bit          prev_busy = 1;
  int          mode = 1;
  logic        ack_man = 1'b0;
  logic        far_ack = 1'b0;
  bit          far_wait = 0;
  int          far_cnt = 0;
  logic [W-1:0] sent_q[$];
  logic [W-1:0] rx_q[$];

  always_comb begin
    case (mode)
      0:       xfer_ack = ack_man;
      1:       xfer_ack = xfer_req;
      default: xfer_ack = far_ack;
    endcase
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (prev_busy && !busy && pending) begin
      done++;
      pending = 0;
    end
    prev_busy = busy;
  end

  // Far-domain receiver: captures the word, answers after 0-20 cycles.
  always @(negedge clk) begin
    if (sreset) begin
      far_ack  = 1'b0;
      far_wait = 0;
    end else if (mode == 2) begin
      if (!far_wait && xfer_req != far_ack) begin
        rx_q.push_back(xfer_data);
        far_wait = 1;
        far_cnt  = $urandom_range(0, 20);
      end
      if (far_wait) begin
        if (far_cnt == 0) begin
          far_ack  = xfer_req;
          far_wait = 0;
        end else begin
          far_cnt--;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] d, output int acc_cyc);
    int n = 0;
    axis_i_tvalid = 1'b1;
    axis_i_tdata  = d;
    while (!axis_i_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!axis_i_tready) begin
      chk("send_timeout", 32'(n), 32'd0);
      axis_i_tvalid = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    pending = 1;
    sent_q.push_back(d);
    @(negedge clk);
    axis_i_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!axis_i_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(axis_i_tready), 32'd1);
  endtask

  task automatic do_reset();
    sreset  = 1'b1;
    pending = 0;
    ack_man = 1'b0;
    repeat (3) @(negedge clk);
    sreset = 1'b0;
  endtask

  initial begin
    int a0, a1, a2, a3, d0, nmis;

    sreset        = 1'b1;
    axis_i_tvalid = 1'b1;
    axis_i_tdata  = 8'h5A;
    mode          = 1;

    // Reset for 3 edges with tvalid held high.
    repeat (3) @(negedge clk);
    chk("rst_tready", 32'(axis_i_tready), 32'd0);
    chk("rst_busy",   32'(busy),          32'd1);
    chk("rst_req",    32'(xfer_req),      32'd0);
    chk("rst_data",   32'(xfer_data),     32'd0);
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
    chk("rst_timeout", 32'(timeout), 32'd0);
`endif
    sreset = 1'b0;
    chk("su_c0", 32'(axis_i_tready), 32'd0);
    @(negedge clk);
    chk("su_c1", 32'(axis_i_tready), 32'd0);
    @(negedge clk);
    chk("su_c2", 32'(axis_i_tready), 32'd1);
    @(negedge clk);
    chk("first_data", 32'(xfer_data), 32'h5A);
    chk("first_req",  32'(xfer_req),  32'd1);
    chk("first_busy", 32'(busy),      32'd1);
    axis_i_tvalid = 1'b0;

    // Loopback, three words back to back from a fresh reset.
    do_reset();
    wait_idle("lb_idle0");
    d0 = done;
    send(8'hA5, a1);
    chk("lb_d0", 32'(xfer_data), 32'hA5);
    chk("lb_r0", 32'(xfer_req),  32'd1);
    send(8'h3C, a2);
    chk("lb_d1", 32'(xfer_data), 32'h3C);
    chk("lb_r1", 32'(xfer_req),  32'd0);
    send(8'hFF, a3);
    chk("lb_d2", 32'(xfer_data), 32'hFF);
    chk("lb_r2", 32'(xfer_req),  32'd1);
    chk("lb_gap01", 32'(a2 - a1), 32'(SS + 2));
    chk("lb_gap12", 32'(a3 - a2), 32'(SS + 2));
    wait_idle("lb_idle1");
    @(negedge clk);
    chk("lb_done", 32'(done - d0), 32'd3);

    // Spurious ack edge while idle.
    ack_man = xfer_req;
    mode    = 0;
    repeat (4) @(negedge clk);
    ack_man = ~ack_man;
    repeat (5) @(negedge clk);
    chk("sp_tready", 32'(axis_i_tready), 32'd1);
    chk("sp_busy",   32'(busy),          32'd0);
    chk("sp_req",    32'(xfer_req),      32'd1);
    send(8'h22, a0);
    chk("sp_data", 32'(xfer_data), 32'h22);
    chk("sp_req2", 32'(xfer_req),  32'd0);
    wait_idle("sp_idle");

`ifdef CDC_HANDSHAKE_TIMEOUT_EN
    // Ack withheld: flag rises after TOUT wait cycles and sticks.
    ack_man = xfer_req;
    send(8'h11, a0);
    repeat (TOUT - 1) @(negedge clk);
    chk("to_before", 32'(timeout), 32'd0);
    chk("to_busy",   32'(busy),    32'd1);
    @(negedge clk);
    chk("to_rise", 32'(timeout), 32'd1);
    repeat (5) @(negedge clk);
    chk("to_hold", 32'(timeout), 32'd1);
    chk("to_wait", 32'(busy),    32'd1);
    ack_man = xfer_req;
    wait_idle("to_idle");
    chk("to_sticky", 32'(timeout), 32'd1);
`endif

    // Reset in the middle of a transfer.
    ack_man = xfer_req;
    send(8'h33, a0);
    @(negedge clk);
    chk("rw_busy",   32'(busy),          32'd1);
    chk("rw_tready", 32'(axis_i_tready), 32'd0);
    chk("rw_data",   32'(xfer_data),     32'h33);
    d0      = done;
    sreset  = 1'b1;
    pending = 0;
    ack_man = 1'b0;
    @(negedge clk);
    sreset = 1'b0;
    chk("rw_req0",  32'(xfer_req),      32'd0);
    chk("rw_data0", 32'(xfer_data),     32'd0);
    chk("rw_start", 32'(axis_i_tready), 32'd0);
    chk("rw_bsy0",  32'(busy),          32'd1);
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
    chk("rw_to0", 32'(timeout), 32'd0);
`endif
    @(negedge clk);
    chk("rw_su1", 32'(axis_i_tready), 32'd0);
    @(negedge clk);
    chk("rw_su2",  32'(axis_i_tready), 32'd1);
    chk("rw_done", 32'(done - d0),     32'd0);

    // 1000 words, random source gaps and far-side delay.
    mode = 2;
    do_reset();
    sent_q.delete();
    rx_q.delete();
    wait_idle("rnd_idle0");
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(W'($urandom), a0);
    end
    begin
      int n = 0;
      while ((rx_q.size() < sent_q.size() || far_wait || !axis_i_tready)
             && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rnd_sent", 32'(sent_q.size()), 32'd1000);
    chk("rnd_rx",   32'(rx_q.size()),   32'd1000);
    nmis = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i >= rx_q.size() || i >= sent_q.size() || rx_q[i] !== sent_q[i])
        nmis++;
    end
    chk("rnd_order", 32'(nmis), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
